// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one line-sized memory controller
//               between the instruction cache (read-only) and the data cache
//               (read / write-back). Grants one transaction at a time,
//               registers the granted request toward the controller, returns
//               the completed line to its owner with a one-cycle valid pulse,
//               and fans the controller invalidate out to both caches.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  // Instruction cache side
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_valid,
  // Data cache side
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_wr_en,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_valid,
  // Memory controller side
  output logic                  mem_start_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr_en,
  input  logic [LINE_WIDTH-1:0] mem_data_out,
  input  logic                  mem_data_valid,
  input  logic                  mem_invalidate,
  output logic                  i_invalidate,
  output logic                  d_invalidate
);

  // Owner encoding for the round-robin pointer
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t                state_q,      state_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
  logic                  mem_wr_en_q,  mem_wr_en_d;
  logic [LINE_WIDTH-1:0] i_rdata_q,    i_rdata_d;
  logic [LINE_WIDTH-1:0] d_rdata_q,    d_rdata_d;
  logic                  i_valid_q,    i_valid_d;
  logic                  d_valid_q,    d_valid_d;
  logic                  i_inv_q,      i_inv_d;
  logic                  d_inv_q,      d_inv_d;

  // Next-state, grant selection, request latching and completion capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wr_en_d  = mem_wr_en_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_valid_d    = 1'b0;
    d_valid_d    = 1'b0;
    // Invalidate is a plain one-cycle delay, independent of arbitration
    i_inv_d      = mem_invalidate;
    d_inv_d      = mem_invalidate;

    case (state_q)
      IDLE: begin
        // On a tie the requester not served last wins; after reset the
        // pointer says I, so the first tie goes to D.
        if (i_req && (!d_req || (last_grant_q == GRANT_D))) begin
          state_d      = BUSY_I;
          last_grant_d = GRANT_I;
          mem_addr_d   = i_addr;
          // I-cache never writes; write data is left as it was
          mem_wr_en_d  = 1'b0;
        end else if (d_req) begin
          state_d      = BUSY_D;
          last_grant_d = GRANT_D;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          mem_wr_en_d  = d_wr_en;
        end
        // A completion pulse seen here belongs to no one and is dropped
      end

      BUSY_I: begin
        if (mem_data_valid) begin
          i_rdata_d = mem_data_out;
          i_valid_d = 1'b1;
          state_d   = IDLE;
        end
      end

      BUSY_D: begin
        // Writes also load d_rdata; the value is meaningless for them
        if (mem_data_valid) begin
          d_rdata_d = mem_data_out;
          d_valid_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_en_q  <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      i_inv_q      <= 1'b0;
      d_inv_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_en_q  <= mem_wr_en_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_valid_q    <= i_valid_d;
      d_valid_q    <= d_valid_d;
      i_inv_q      <= i_inv_d;
      d_inv_q      <= d_inv_d;
    end
  end

  // Start request is a pure decode of the busy states, so it drops on the
  // same edge that returns to IDLE and forces one idle cycle between grants.
  assign mem_start_req = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wr_en     = mem_wr_en_q;
  assign i_rdata       = i_rdata_q;
  assign d_rdata       = d_rdata_q;
  assign i_valid       = i_valid_q;
  assign d_valid       = d_valid_q;
  assign i_invalidate  = i_inv_q;
  assign d_invalidate  = d_inv_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_valid;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_wr_en;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_valid;
  logic          mem_start_req;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_wr_en;
  logic [LW-1:0] mem_data_out;
  logic          mem_data_valid;
  logic          mem_invalidate;
  logic          i_invalidate;
  logic          d_invalidate;

  int checks = 0;
  int errors = 0;

  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_p;
  logic [LW-1:0] pat_x;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req          (i_req),
    .i_addr         (i_addr),
    .i_rdata        (i_rdata),
    .i_valid        (i_valid),
    .d_req          (d_req),
    .d_addr         (d_addr),
    .d_wr_en        (d_wr_en),
    .d_wdata        (d_wdata),
    .d_rdata        (d_rdata),
    .d_valid        (d_valid),
    .mem_start_req  (mem_start_req),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wr_en      (mem_wr_en),
    .mem_data_out   (mem_data_out),
    .mem_data_valid (mem_data_valid),
    .mem_invalidate (mem_invalidate),
    .i_invalidate   (i_invalidate),
    .d_invalidate   (d_invalidate)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    pat_a5 = {64{8'hA5}};
    pat_p  = {16{32'hDEADBEEF}};
    pat_x  = {16{32'h0BADF00D}};

    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_addr = '0;
    d_wr_en = 1'b0; d_wdata = '0; mem_data_out = '0; mem_data_valid = 1'b0;
    mem_invalidate = 1'b0;

    // ---------------- reset ----------------
    step(); step();
    chk("rst_start",   mem_start_req, 0);
    chk("rst_addr",    mem_addr, 0);
    chk("rst_wdata",   mem_wdata, 0);
    chk("rst_wr_en",   mem_wr_en, 0);
    chk("rst_i_valid", i_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_i_inv",   i_invalidate, 0);
    chk("rst_d_inv",   d_invalidate, 0);
    rst = 1'b0;
    step();

    // ---------------- I-cache read ----------------
    i_req = 1'b1; i_addr = 64'h1000;
    step();
    chk("ird_start", mem_start_req, 1);
    chk("ird_addr",  mem_addr, 64'h1000);
    chk("ird_wr_en", mem_wr_en, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("ird_wait_start", mem_start_req, 1);
      chk("ird_wait_valid", i_valid, 0);
    end
    mem_data_valid = 1'b1; mem_data_out = pat_a5;
    step();
    mem_data_valid = 1'b0; i_req = 1'b0;
    chk("ird_valid",   i_valid, 1);
    chk("ird_rdata",   i_rdata, pat_a5);
    chk("ird_d_valid", d_valid, 0);
    chk("ird_start_low", mem_start_req, 0);
    step();
    chk("ird_valid_once", i_valid, 0);
    chk("ird_idle", mem_start_req, 0);

    // ---------------- D-cache write ----------------
    d_req = 1'b1; d_wr_en = 1'b1; d_addr = 64'h2040; d_wdata = pat_p;
    step();
    chk("dwr_start", mem_start_req, 1);
    chk("dwr_addr",  mem_addr, 64'h2040);
    chk("dwr_wr_en", mem_wr_en, 1);
    chk("dwr_wdata", mem_wdata, pat_p);
    // Inputs are ignored while busy: outputs must stay frozen
    d_wdata = pat_x; d_addr = 64'h9999;
    step(); step();
    chk("dwr_wdata_held", mem_wdata, pat_p);
    chk("dwr_addr_held",  mem_addr, 64'h2040);
    chk("dwr_wr_en_held", mem_wr_en, 1);
    mem_data_valid = 1'b1; mem_data_out = 512'h77;
    step();
    mem_data_valid = 1'b0; d_req = 1'b0; d_wr_en = 1'b0; d_wdata = pat_p;
    chk("dwr_valid",   d_valid, 1);
    chk("dwr_i_valid", i_valid, 0);
    chk("dwr_start_low", mem_start_req, 0);
    chk("dwr_i_rdata_kept", i_rdata, pat_a5);
    step();
    chk("dwr_valid_once", d_valid, 0);

    // ---------------- reset while BUSY_I ----------------
    i_req = 1'b1; i_addr = 64'h5000;
    step();
    chk("rbi_start", mem_start_req, 1);
    step();
    rst = 1'b1; i_req = 1'b0;
    step();
    chk("rbi_start_low", mem_start_req, 0);
    chk("rbi_i_valid",   i_valid, 0);
    rst = 1'b0;
    step();
    chk("rbi_i_valid_later", i_valid, 0);
    chk("rbi_idle", mem_start_req, 0);

    // ---------------- contention: D, I, D, I ----------------
    i_req = 1'b1; i_addr = 64'h4000;
    d_req = 1'b1; d_addr = 64'h3000; d_wr_en = 1'b0;
    step();
    chk("ct1_start", mem_start_req, 1);
    chk("ct1_addr_d", mem_addr, 64'h3000);
    chk("ct1_wr_en", mem_wr_en, 0);
    step();
    mem_data_valid = 1'b1; mem_data_out = 512'h11;
    step();
    mem_data_valid = 1'b0;
    chk("ct1_d_valid", d_valid, 1);
    chk("ct1_d_rdata", d_rdata, 512'h11);
    chk("ct1_gap", mem_start_req, 0);
    step();
    chk("ct2_start", mem_start_req, 1);
    chk("ct2_addr_i", mem_addr, 64'h4000);
    chk("ct2_wr_en", mem_wr_en, 0);
    chk("ct2_d_valid_low", d_valid, 0);
    mem_data_valid = 1'b1; mem_data_out = 512'h22;
    step();
    mem_data_valid = 1'b0;
    chk("ct2_i_valid", i_valid, 1);
    chk("ct2_i_rdata", i_rdata, 512'h22);
    chk("ct2_gap", mem_start_req, 0);
    step();
    chk("ct3_start", mem_start_req, 1);
    chk("ct3_addr_d", mem_addr, 64'h3000);
    mem_data_valid = 1'b1; mem_data_out = 512'h33;
    step();
    mem_data_valid = 1'b0;
    chk("ct3_d_valid", d_valid, 1);
    chk("ct3_d_rdata", d_rdata, 512'h33);
    chk("ct3_gap", mem_start_req, 0);
    step();
    chk("ct4_start", mem_start_req, 1);
    chk("ct4_addr_i", mem_addr, 64'h4000);
    mem_data_valid = 1'b1; mem_data_out = 512'h44;
    step();
    mem_data_valid = 1'b0; i_req = 1'b0; d_req = 1'b0;
    chk("ct4_i_valid", i_valid, 1);
    chk("ct4_i_rdata", i_rdata, 512'h44);
    step();
    chk("ct_end_idle", mem_start_req, 0);

    // ---------------- spurious completion in IDLE ----------------
    mem_data_valid = 1'b1; mem_data_out = {LW{1'b1}};
    step();
    mem_data_valid = 1'b0;
    chk("spur_start",   mem_start_req, 0);
    chk("spur_i_valid", i_valid, 0);
    chk("spur_d_valid", d_valid, 0);
    chk("spur_i_rdata", i_rdata, 512'h44);
    chk("spur_d_rdata", d_rdata, 512'h33);
    step();
    chk("spur_still_idle", mem_start_req, 0);

    // ---------------- invalidate fan-out ----------------
    mem_invalidate = 1'b1;
    #1;
    chk("inv_not_yet_i", i_invalidate, 0);
    chk("inv_not_yet_d", d_invalidate, 0);
    step();
    mem_invalidate = 1'b0;
    chk("inv_i", i_invalidate, 1);
    chk("inv_d", d_invalidate, 1);
    step();
    chk("inv_i_clear", i_invalidate, 0);
    chk("inv_d_clear", d_invalidate, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
